aead_serial_frontend: RTL and testbench

AEAD_SERIAL_FRONTEND -- requirements
Module: aead_serial_frontend

---
 rtl/aead_serial_frontend_if.sv | 54 +++++
 rtl/aead_serial_frontend.sv | 184 ++++++++++++++++++
 tb/tb_aead_serial_frontend.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aead_serial_frontend_if.sv
// Handshake and operand bundle between the AEAD serial front end and its environment.
interface aead_serial_frontend_if #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40,
  parameter int W = 1
);
  logic         start;
  logic         mode;
  logic         in_valid;
  logic [W-1:0] key_in;
  logic [W-1:0] nonce_in;
  logic [W-1:0] ad_in;
  logic [W-1:0] data_in;
  logic [W-1:0] tag_in;

  logic [K-1:0] core_key;
  logic [127:0] core_nonce;
  logic [L-1:0] core_ad;
  logic [Y-1:0] core_data;
  logic [127:0] core_tag_exp;
  logic         core_enc_start;
  logic         core_dec_start;
  logic         core_done;
  logic [Y-1:0] core_text;
  logic [127:0] core_tag;

  logic         out_ready;
  logic         out_valid;
  logic         out_last;
  logic [W-1:0] text_out;
  logic [W-1:0] tag_out;

  logic         busy;
  logic         auth_ok;
  logic         auth_fail;
  logic [2:0]   state_dbg;

  modport master (
    output start, mode, in_valid, key_in, nonce_in, ad_in, data_in, tag_in,
           core_done, core_text, core_tag, out_ready,
    input  core_key, core_nonce, core_ad, core_data, core_tag_exp,
           core_enc_start, core_dec_start, out_valid, out_last, text_out, tag_out,
           busy, auth_ok, auth_fail, state_dbg
  );

  modport slave (
    input  start, mode, in_valid, key_in, nonce_in, ad_in, data_in, tag_in,
           core_done, core_text, core_tag, out_ready,
    output core_key, core_nonce, core_ad, core_data, core_tag_exp,
           core_enc_start, core_dec_start, out_valid, out_last, text_out, tag_out,
           busy, auth_ok, auth_fail, state_dbg
  );
endinterface

// File: rtl/aead_serial_frontend.sv
// Serial front end for an AEAD core: loads operands MSB-first, kicks the core, serialises results.
// Optional macro AEAD_FRONTEND_RANDOM_MASK_EN replaces the zero failure mask with LFSR bits.
module aead_serial_frontend #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40,
  parameter int W = 1
) (
  input logic                  clk,
  input logic                  rst,
  aead_serial_frontend_if.slave bus
);
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NK     = K / W;
  localparam int NN     = 128 / W;
  localparam int NA     = L / W;
  localparam int NY     = Y / W;
  localparam int NT     = 128 / W;
  localparam int NL     = imax(imax(NK, NN), imax(NA, NY));
  localparam int NU_ENC = imax(NY, NT);
  localparam int CW     = $clog2(NL + 1);

  if ((K % W) != 0 || (L % W) != 0 || (Y % W) != 0 || (128 % W) != 0) begin : g_bad_w
    $error("W must divide K, L, Y and 128");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KICK   = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rst_sync_q;
  logic          mode_q;
  logic [CW-1:0] cnt_q;
  logic [K-1:0]  key_q;
  logic [127:0]  nonce_q;
  logic [L-1:0]  ad_q;
  logic [Y-1:0]  data_q;
  logic [127:0]  tag_exp_q;
  logic [Y-1:0]  text_sr;
  logic [127:0]  tag_sr;
  logic          auth_ok_q, auth_fail_q;
  logic [W-1:0]  mask;

  // Handshakes: an output beat transfers on a rising edge where out_valid && out_ready and
  // holds unchanged until then; in_valid has no back-pressure, every valid LOAD beat is taken.
  logic          start_ok, out_fire, last_beat;
  logic [CW-1:0] nu_cnt;

  assign start_ok  = bus.start && rst_sync_q;
  assign out_fire  = (state_q == S_UNLOAD) && bus.out_ready;
  assign nu_cnt    = mode_q ? CW'(NY) : CW'(NU_ENC);
  assign last_beat = (cnt_q == nu_cnt - CW'(1));

  // One flop of release synchronisation: the first start lands on the 2nd edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 1'b0;
    else      rst_sync_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_LOAD;
      S_LOAD:   if (bus.in_valid && cnt_q == CW'(NL - 1)) state_d = S_KICK;
      S_KICK:   state_d = S_WAIT;
      S_WAIT:   if (bus.core_done) state_d = S_UNLOAD;
      S_UNLOAD: if (out_fire && last_beat) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      ad_q        <= '0;
      data_q      <= '0;
      tag_exp_q   <= '0;
      text_sr     <= '0;
      tag_sr      <= '0;
      auth_ok_q   <= 1'b0;
      auth_fail_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_ok) begin
          mode_q      <= bus.mode;
          cnt_q       <= '0;
          auth_ok_q   <= 1'b0;
          auth_fail_q <= 1'b0;
        end
        S_LOAD: if (bus.in_valid) begin
          cnt_q <= (cnt_q == CW'(NL - 1)) ? '0 : cnt_q + 1'b1;
          // Shorter operands stop shifting once full, so their extra beats are dropped.
          if (cnt_q < CW'(NK)) key_q     <= (key_q << W)     | K'(bus.key_in);
          if (cnt_q < CW'(NN)) nonce_q   <= (nonce_q << W)   | 128'(bus.nonce_in);
          if (cnt_q < CW'(NA)) ad_q      <= (ad_q << W)      | L'(bus.ad_in);
          if (cnt_q < CW'(NY)) data_q    <= (data_q << W)    | Y'(bus.data_in);
          if (cnt_q < CW'(NT)) tag_exp_q <= (tag_exp_q << W) | 128'(bus.tag_in);
        end
        S_WAIT: if (bus.core_done) begin
          text_sr <= bus.core_text;
          tag_sr  <= bus.core_tag;
          if (mode_q) begin
            auth_ok_q   <= (bus.core_tag == tag_exp_q);
            auth_fail_q <= (bus.core_tag != tag_exp_q);
          end
        end
        S_UNLOAD: if (bus.out_ready) begin
          cnt_q   <= last_beat ? '0 : cnt_q + 1'b1;
          text_sr <= text_sr << W;
          tag_sr  <= tag_sr << W;
        end
        default: ;
      endcase
    end
  end

`ifdef AEAD_FRONTEND_RANDOM_MASK_EN
  logic [31:0]  lfsr_q;
  logic [W-1:0] mask_q;

  // The mask is sampled per presented beat so a stalled beat keeps its value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 32'hACE1ACE1;
      mask_q <= '0;
    end else begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h80200003) : (lfsr_q >> 1);
      if ((state_q == S_WAIT && bus.core_done) || out_fire)
        mask_q <= W'({4{lfsr_q}} >> (128 - W));
    end
  end
  assign mask = mask_q;
`else
  assign mask = '0;
`endif

  assign bus.core_key     = key_q;
  assign bus.core_nonce   = nonce_q;
  assign bus.core_ad      = ad_q;
  assign bus.core_data    = data_q;
  assign bus.core_tag_exp = tag_exp_q;
  assign bus.auth_ok      = auth_ok_q;
  assign bus.auth_fail    = auth_fail_q;
  assign bus.state_dbg    = state_q;

  always_comb begin
    bus.busy           = (state_q != S_IDLE);
    bus.core_enc_start = 1'b0;
    bus.core_dec_start = 1'b0;
    bus.out_valid      = 1'b0;
    bus.out_last       = 1'b0;
    bus.text_out       = '0;
    bus.tag_out        = '0;
    case (state_q)
      S_KICK: begin
        bus.core_enc_start = !mode_q;
        bus.core_dec_start = mode_q;
      end
      S_UNLOAD: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_beat;
        if (cnt_q < CW'(NY)) bus.text_out = auth_fail_q ? mask : text_sr[Y-1 -: W];
        if (!mode_q && cnt_q < CW'(NT)) bus.tag_out = tag_sr[127 -: W];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aead_serial_frontend.sv
// Randomised job-level bench: a W=8 instance checked beat by beat against a queue model,
// plus a W=1 instance driven through a full all-zero encrypt job.
module tb_aead_serial_frontend;
  localparam int NL8 = 16;
  localparam int NY8 = 5;
  localparam int NT8 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aead_serial_frontend_if #(.K(128), .L(40), .Y(40), .W(8)) bus8 ();
  aead_serial_frontend_if #(.K(128), .L(40), .Y(40), .W(1)) bus1 ();

  aead_serial_frontend #(.K(128), .L(40), .Y(40), .W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  aead_serial_frontend #(.K(128), .L(40), .Y(40), .W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;
  int kicks_enc = 0;
  int kicks_dec = 0;
  // {text_care, text, tag, last}
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Beat k of an len-bit operand sent MSB-first in bytes; beats past the operand are 0.
  function automatic logic [7:0] beat8(input logic [127:0] v, input int len, input int k);
    logic [127:0] t;
    if (k >= len / 8) return 8'h00;
    t = v >> (len - 8 * (k + 1));
    return t[7:0];
  endfunction

  task automatic idle8();
    bus8.start = 0; bus8.mode = 0; bus8.in_valid = 0;
    bus8.key_in = '0; bus8.nonce_in = '0; bus8.ad_in = '0; bus8.data_in = '0; bus8.tag_in = '0;
    bus8.core_done = 0; bus8.core_text = '0; bus8.core_tag = '0; bus8.out_ready = 0;
  endtask

  task automatic idle1();
    bus1.start = 0; bus1.mode = 0; bus1.in_valid = 0;
    bus1.key_in = '0; bus1.nonce_in = '0; bus1.ad_in = '0; bus1.data_in = '0; bus1.tag_in = '0;
    bus1.core_done = 0; bus1.core_text = '0; bus1.core_tag = '0; bus1.out_ready = 0;
  endtask

  task automatic reset_pulse();
    idle8();
    idle1();
    rst = 1'b0;
    #1;
    chk("rst_busy", {bus8.busy, bus1.busy}, 0);
    chk("rst_outputs", {bus8.out_valid, bus8.out_last, bus8.text_out, bus8.tag_out,
                        bus8.core_enc_start, bus8.core_dec_start, bus8.auth_ok, bus8.auth_fail}, 0);
    chk("rst_core_key", bus8.core_key, 0);
    chk("rst_core_data", {bus8.core_data, bus8.core_ad}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output scoreboard: every presented beat must equal the queue head, popped on handshake.
  always @(negedge clk) begin
    logic [16:0] act;
    logic [17:0] e;
    if (bus8.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_beat_extra: got beat %h expected none", {bus8.text_out, bus8.tag_out});
      end else begin
        e = exp_q[0];
        act = {bus8.text_out, bus8.tag_out, bus8.out_last};
        if (!e[17]) act[16:9] = e[16:9];
        chk("out_beat", act, e[16:0]);
        if (bus8.out_ready) void'(exp_q.pop_front());
      end
    end
    if (bus8.core_enc_start) kicks_enc++;
    if (bus8.core_dec_start) kicks_dec++;
  end

  // abort: 0 full job, 1 reset while waiting for the core, 2 reset mid-unload.
  task automatic run_job(input bit mode, input bit tag_match, input int abort, input bit toggle);
    logic [127:0] key, nonce, tag_exp, ctag;
    logic [39:0]  ad, data, ctext;
    int nu, sent, cyc, e0, d0;
    bit fail;
    key = r128(); nonce = r128(); tag_exp = r128();
    ad = 40'(r128()); data = 40'(r128());
    e0 = kicks_enc; d0 = kicks_dec;

    bus8.start = 1; bus8.mode = mode;
    @(posedge clk); #1;
    bus8.mode = ~mode;
    chk("busy_after_start", bus8.busy, 1);
    chk("auth_cleared", {bus8.auth_ok, bus8.auth_fail}, 0);

    for (int i = 0; i < NL8; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus8.in_valid = 0;
        bus8.key_in = 8'($urandom); bus8.ad_in = 8'($urandom); bus8.tag_in = 8'($urandom);
        bus8.start = 1'($urandom_range(0, 1));
        bus8.core_done = 1'($urandom_range(0, 1)); bus8.core_text = 40'(r128());
        @(posedge clk); #1;
      end
      bus8.in_valid = 1;
      bus8.key_in   = beat8(key, 128, i);
      bus8.nonce_in = beat8(nonce, 128, i);
      bus8.tag_in   = beat8(tag_exp, 128, i);
      bus8.ad_in    = (i < NY8) ? beat8(ad, 40, i) : 8'($urandom);
      bus8.data_in  = (i < NY8) ? beat8(data, 40, i) : 8'($urandom);
      bus8.start    = 1'($urandom_range(0, 1));
      bus8.core_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus8.in_valid = 0; bus8.start = 0; bus8.core_done = 0;
    chk("kick_enc", bus8.core_enc_start, !mode);
    chk("kick_dec", bus8.core_dec_start, mode);
    chk("core_key", bus8.core_key, key);
    chk("core_nonce", bus8.core_nonce, nonce);
    chk("core_tag_exp", bus8.core_tag_exp, tag_exp);
    chk("core_ad_data", {bus8.core_ad, bus8.core_data}, {ad, data});

    repeat ($urandom_range(1, 4)) begin
      @(posedge clk); #1;
      bus8.in_valid = 1'($urandom_range(0, 1)); bus8.key_in = 8'($urandom);
      bus8.start = 1'($urandom_range(0, 1));
    end
    chk("one_kick_enc", kicks_enc - e0, !mode);
    chk("one_kick_dec", kicks_dec - d0, mode);

    if (abort == 1) begin
      reset_pulse();
      bus8.core_done = 1; bus8.core_text = 40'(r128());
      settle();
      chk("wait_rst_idle", {bus8.busy, bus8.out_valid, bus8.text_out, bus8.tag_out}, 0);
      chk("wait_rst_key", bus8.core_key, 0);
      chk("wait_rst_no_kick", kicks_enc + kicks_dec - e0 - d0, 1);
      bus8.core_done = 0;
      return;
    end

    fail = mode && !tag_match;
    ctext = 40'(r128());
    ctag = mode ? (tag_match ? tag_exp : tag_exp ^ 128'h1) : r128();
    nu = mode ? NY8 : NT8;
    for (int k = 0; k < nu; k++) begin
`ifdef AEAD_FRONTEND_RANDOM_MASK_EN
      exp_q.push_back({!fail, fail ? 8'h00 : beat8(ctext, 40, k),
                       mode ? 8'h00 : beat8(ctag, 128, k), k == nu - 1});
`else
      exp_q.push_back({1'b1, fail ? 8'h00 : beat8(ctext, 40, k),
                       mode ? 8'h00 : beat8(ctag, 128, k), k == nu - 1});
`endif
    end
    bus8.in_valid = 0; bus8.start = 0;
    bus8.core_done = 1; bus8.core_text = ctext; bus8.core_tag = ctag;
    @(posedge clk); #1;
    bus8.core_done = 0;
    chk("auth_ok", bus8.auth_ok, mode && tag_match);
    chk("auth_fail", bus8.auth_fail, fail);

    sent = 0;
    cyc = 0;
    while (sent < nu && cyc < 400) begin
      if (abort == 2 && sent == 2) begin
        reset_pulse();
        exp_q.delete();
        settle();
        chk("unload_rst_idle", {bus8.busy, bus8.out_valid, bus8.out_last, bus8.text_out}, 0);
        return;
      end
      bus8.out_ready = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      bus8.start = (nu - sent > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus8.core_done = 1'($urandom_range(0, 1)); bus8.core_text = 40'(r128());
      bus8.in_valid = 1'($urandom_range(0, 1)); bus8.key_in = 8'($urandom);
      @(posedge clk); #1;
      if (bus8.out_ready) sent++;
      cyc++;
    end
    idle8();
    chk("unload_budget", cyc < 400, 1);
    chk("sb_drained", exp_q.size(), 0);
    chk("idle_after_job", {bus8.busy, bus8.out_valid}, 0);
    chk("auth_hold", {bus8.auth_ok, bus8.auth_fail}, {mode && tag_match, fail});
    chk("key_held", bus8.core_key, key);
    chk("data_held", bus8.core_data, data);
    chk("kicks_per_job", kicks_enc + kicks_dec - e0 - d0, 1);
  endtask

  task automatic run_w1();
    logic [127:0] ctag;
    logic [39:0]  ctext;
    bit early;
    idle1();
    early = 0;
    bus1.start = 1; bus1.mode = 0;
    @(posedge clk); #1;
    bus1.start = 0; bus1.in_valid = 1;
    for (int i = 0; i < 128; i++) begin
      if (bus1.core_enc_start || bus1.core_dec_start) early = 1;
      @(posedge clk); #1;
    end
    bus1.in_valid = 0;
    chk("w1_no_early_kick", early, 0);
    chk("w1_kick_after_128", {bus1.core_enc_start, bus1.core_dec_start}, 2'b10);
    @(posedge clk); #1;
    chk("w1_kick_one_cycle", bus1.core_enc_start, 0);
    ctext = 40'(r128()); ctag = r128();
    bus1.core_done = 1; bus1.core_text = ctext; bus1.core_tag = ctag;
    @(posedge clk); #1;
    bus1.core_done = 0; bus1.out_ready = 1;
    for (int k = 0; k < 128; k++) begin
      chk("w1_beat", {bus1.out_valid, bus1.text_out, bus1.tag_out, bus1.out_last},
          {1'b1, (k < 40) ? ctext[39 - k] : 1'b0, ctag[127 - k], k == 127});
      @(posedge clk); #1;
    end
    chk("w1_idle", {bus1.busy, bus1.out_valid}, 0);
    idle1();
  endtask

  initial begin
    idle8();
    idle1();
    chk("model_ad_beat0", beat8(128'hA1B2C3D4E5, 40, 0), 8'hA1);
    chk("model_ad_beat4", beat8(128'hA1B2C3D4E5, 40, 4), 8'hE5);
    chk("model_ad_beat5", beat8(128'hA1B2C3D4E5, 40, 5), 8'h00);
    chk("model_tag_beat15", beat8(128'h0F000000_00000000_00000000_0000003C, 128, 15), 8'h3C);
    #3;
    reset_pulse();
    bus8.start = 1;
    @(posedge clk); #1;
    chk("start_edge1_ignored", bus8.busy, 0);
    @(posedge clk); #1;
    chk("start_edge2_taken", bus8.busy, 1);
    bus8.start = 0; bus8.in_valid = 1; bus8.key_in = 8'hFF;
    @(posedge clk); #1;
    chk("load_one_beat", bus8.core_key, 128'hFF);
    reset_pulse();
    settle();
    chk("idle_after_load_rst", {bus8.busy, bus8.core_key}, 0);

    run_w1();
    run_job(0, 0, 0, 0);
    run_job(1, 1, 0, 0);
    run_job(1, 0, 0, 0);
    run_job(0, 0, 0, 1);
    run_job(1, 1, 0, 1);
    run_job(1, 0, 1, 0);
    run_job(0, 0, 2, 1);
    run_job(1, 1, 0, 0);
    for (int j = 0; j < 12; j++)
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
